// File: rtl/task_read_port_pkg.sv
// Shared types and defaults for the task-based read port and its register bank.
package task_read_port_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 2;
  localparam int DEF_CNT_W = 8;

  // 2'd3 is unused; the FSM treats it as illegal and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/task_read_port_if.sv
// Write strobe plus read request/response bundle for task_read_port.
interface task_read_port_if #(
  parameter int DW    = 8,
  parameter int AW    = 2,
  parameter int CNT_W = 8
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [AW-1:0]    rd_req_addr;
  logic             rd_valid;
  logic             rd_ready;
  logic [DW-1:0]    rd_data;
  logic [CNT_W-1:0] rd_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_ready,
    input  rd_req_ready, rd_valid, rd_data, rd_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_ready,
    output rd_req_ready, rd_valid, rd_data, rd_count
  );
endinterface

// File: rtl/task_reg_bank.sv
// Register bank with an always-accepted write port and a registered fetch
// port; the fetch sees a same-cycle write to its address (write-first).
module task_reg_bank #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          fetch_en,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_data
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][DW-1:0] bank_r;
  logic [DEPTH-1:0][DW-1:0] bank_nxt_s;
  logic [DEPTH-1:0][DW-1:0] bank_clr_s;
  logic [DW-1:0]            fetch_s;
  logic [DW-1:0]            data_r;

  task automatic clear_bank(output logic [DEPTH-1:0][DW-1:0] img);
    img = '0;
  endtask

  task automatic read_data(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    if (wr_en && (wr_addr == addr)) begin
      data = wr_data;
    end else begin
      data = bank_r[addr];
    end
  endtask

  // Next bank image, cleared image and bypassed fetch value.
  always_comb begin
    bank_nxt_s = bank_r;
    if (wr_en) begin
      bank_nxt_s[wr_addr] = wr_data;
    end else begin
      bank_nxt_s = bank_r;
    end
    clear_bank(bank_clr_s);
    read_data(fetch_addr, fetch_s);
  end

  // Storage and the held fetch result; data_r only moves on a fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_r <= '0;
      data_r <= '0;
    end else begin
      bank_r <= bank_nxt_s;
      if (fetch_en) begin
        data_r <= fetch_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign fetch_data = data_r;

endmodule

// File: rtl/task_read_port.sv
// Read request/response FSM over task_reg_bank: one request in flight,
// IDLE -> FETCH -> RESP, with a wrapping completed-read counter.
module task_read_port
  import task_read_port_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  task_read_port_if.slave bus
);

  state_t           state_r;
  logic [AW-1:0]    addr_r;
  logic             rd_req_ready_r;
  logic             rd_valid_r;
  logic [CNT_W-1:0] rd_count_r;
  logic             fetch_en_s;
  logic [DW-1:0]    data_s;

  assign fetch_en_s = (state_r == S_FETCH);

  task_reg_bank #(.DW(DW), .AW(AW)) u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .wr_data    (bus.wr_data),
    .fetch_en   (fetch_en_s),
    .fetch_addr (addr_r),
    .fetch_data (data_s)
  );

  // Handshake FSM with registered ready/valid and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      addr_r         <= '0;
      rd_req_ready_r <= 1'b0;
      rd_valid_r     <= 1'b0;
      rd_count_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          rd_valid_r <= 1'b0;
          if (bus.rd_req_valid && rd_req_ready_r) begin
            addr_r         <= bus.rd_req_addr;
            rd_req_ready_r <= 1'b0;
            state_r        <= S_FETCH;
          end else begin
            rd_req_ready_r <= 1'b1;
            state_r        <= S_IDLE;
          end
        end
        S_FETCH: begin
          rd_req_ready_r <= 1'b0;
          rd_valid_r     <= 1'b1;
          state_r        <= S_RESP;
        end
        S_RESP: begin
          if (bus.rd_ready) begin
            rd_valid_r     <= 1'b0;
            rd_req_ready_r <= 1'b1;
            rd_count_r     <= rd_count_r + CNT_W'(1);
            state_r        <= S_IDLE;
          end else begin
            rd_valid_r     <= 1'b1;
            rd_req_ready_r <= 1'b0;
            state_r        <= S_RESP;
          end
        end
        default: begin
          rd_valid_r     <= 1'b0;
          rd_req_ready_r <= 1'b0;
          state_r        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_req_ready = rd_req_ready_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.rd_data      = data_s;
  assign bus.rd_count     = rd_count_r;

endmodule
